timer_apb_master: RTL and testbench
===================================

# timer_apb_master

APB3 master bridge that sits directly upstream of `timer_top` and drives its `psel`/`penable`/`pwrite`/`paddr`/`pwdata` bus from a simple valid/ready command port. It returns `prdata` and a completion/error response. It is used by the embedded CPU model and by the system-level bench, so that timer register traffic goes through one protocol-correct sequencer instead of hand-driven pins. It issues one transfer at a time, waits on `pready`, and can optionally abort hung transfers.

## Interface
Parameters:
- `ADDR_W`, 8: width of `cmd_addr`/`paddr`.
- `DATA_W`, 8: width of write/read data.
- `TIMEOUT_CYC`, 16: maximum ACCESS cycles without `pready` before abort (only with `APB_TIMEOUT_EN`); legal range 1..255.

Ports:
- `pclk` input 1: the only clock; all logic is on the rising edge.
- `presetn` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_W: register address.
- `cmd_wdata` input DATA_W: write data.
- `rsp_valid` output 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` output DATA_W: read data; 0 for writes and aborts.
- `rsp_err` output 1: 1 = transfer aborted by timeout.
- `busy` output 1: high in SETUP and ACCESS.
- `psel`, `penable`, `pwrite` outputs 1: APB control.
- `paddr` output ADDR_W: APB address.
- `pwdata` output DATA_W: APB write data.
- `prdata` input DATA_W: APB read data.
- `pready` input 1: APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - `cmd_ready=1`, `psel=0`, `penable=0`.
  - On handshake: capture write/addr/wdata into `pwrite`/`paddr`/`pwdata`, then go to SETUP.
- SETUP (exactly 1 cycle):
  - `psel=1`, `penable=0`. `pready` is ignored.
  - Go to ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`. `paddr`/`pwrite`/`pwdata` are held stable.
  - If `pready=1`: next cycle `rsp_valid=1`, `rsp_err=0`; `rsp_rdata` = sampled `prdata` for reads, 0 for writes. Go to IDLE.
  - If `pready=0`: stay in ACCESS.
- `cmd_ready=0` in SETUP and ACCESS. A `cmd_valid` in those states is ignored; the requester holds it.
- `paddr`/`pwrite`/`pwdata` keep their last values while IDLE. `psel`/`penable` are never high in IDLE.
- `rsp_rdata`/`rsp_err` hold their values until the next response.
- Reset mid-operation:
  - All outputs go to reset values immediately and the state becomes IDLE.
  - The in-flight command is dropped and no `rsp_valid` is issued for it.
- Abort (`APB_TIMEOUT_EN` only):
  - A wait counter clears on SETUP entry and increments each ACCESS cycle with `pready=0`.
  - When `pready=0` in the `TIMEOUT_CYC`-th ACCESS cycle, the transfer aborts.
  - Next cycle: `psel=penable=0`, `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`, state IDLE.
  - If `pready=1` in that same cycle, `pready` wins and the transfer completes normally.
  - Counter width is $clog2(TIMEOUT_CYC+1).

## Timing
- Reset values: `cmd_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `busy=0`, `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`.
- Handshake at cycle N gives SETUP at N+1 and first ACCESS at N+2.
- With `pready=1` at N+2: `rsp_valid` at N+3. In that cycle the state is IDLE with `cmd_ready=1`.
- Minimum cadence is one command per 3 cycles.
- Each wait state adds 1 cycle to the ACCESS phase.
- Latency from handshake to `rsp_valid` is 3 + wait states (timeout: 2 + `TIMEOUT_CYC`).

## Configuration
- Macro `TIMER_APB_MASTER_TIMEOUT_EN`, abbreviated above as `APB_TIMEOUT_EN`.
- Defined: the wait counter and abort path are built; `rsp_err` is functional.
- Undefined:
  - No counter; ACCESS waits indefinitely for `pready`.
  - `rsp_err` is tied to 0 and `TIMEOUT_CYC` is unused.

## Test plan
- Write 0x05 to 0x00, `pready=1`:
  - SETUP cycle shows `psel=1`, `penable=0`, `pwrite=1`, `paddr=0x00`, `pwdata=0x05`.
  - Next cycle `penable=1`; `rsp_valid` one cycle later with `rsp_err=0`, `rsp_rdata=0x00`.
- Read 0x02, `pready` low for 3 ACCESS cycles, then high with `prdata=0xA5`:
  - `penable` high for 4 cycles with `paddr` stable.
  - `rsp_rdata=0xA5`; latency 6 cycles.
- Macro defined, `TIMEOUT_CYC=16`:
  - `pready` stuck 0: abort after 16 ACCESS cycles; `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0x00`, `psel=0`.
  - `pready=1` on the 16th ACCESS cycle: normal completion with `rsp_err=0`.
  - Macro undefined: still in ACCESS with `psel=1` after 100 cycles.
- `presetn` pulsed low during ACCESS:
  - `psel` and `penable` drop asynchronously.
  - No `rsp_valid` after release; `cmd_ready=1` in the first cycle after release.
- `cmd_valid` held high for 3 commands (write 0x01 to 0x00, write 0x82 to 0x01, read 0x03), `pready=1`:
  - Handshakes every 3 cycles; `cmd_ready=0` and `busy=1` during SETUP/ACCESS.
  - Exactly 3 `rsp_valid` pulses, in order.

Source files
------------

// File: rtl/timer_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_master
// Brief    : Valid/ready command port to APB3 master bridge for timer_top.
//            Optional hung-transfer abort when TIMER_APB_MASTER_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module timer_apb_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
        $error("timer_apb_master: TIMEOUT_CYC must be in 1..255");
    end

    logic [1:0]        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic abort;
    logic xfer_end;

    assign accept   = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign xfer_end = (state_q == S_ACCESS) && (pready || abort);

`ifdef TIMER_APB_MASTER_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rsp_err_q, rsp_err_d;

    // Counter holds the number of ACCESS cycles already spent without pready.
    assign abort = (state_q == S_ACCESS) && !pready && (wait_q == LAST_WAIT);

    always_comb begin
        wait_d    = '0;
        rsp_err_d = rsp_err_q;
        if ((state_q == S_ACCESS) && !pready) begin
            wait_d = wait_q + 1'b1;
        end
        if (xfer_end) begin
            rsp_err_d = abort;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign abort   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (xfer_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so each one is derived from the next state.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        psel_d      = (state_d != S_IDLE);
        penable_d   = (state_d == S_ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = xfer_end;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end
        if (xfer_end) begin
            rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_master.sv
`default_nettype none
// Bench for timer_apb_master: a per-cycle timeline is derived from a transaction
// list and every output is compared against it each cycle, then a mid-transfer reset.
module tb_timer_apb_master;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int TO   = 16;
    localparam int MAXC = 2048;
    localparam int NTX  = 48;
`ifdef TIMER_APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          pclk;
    logic          presetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    timer_apb_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Stimulus per cycle
    logic        in_valid  [MAXC];
    logic        in_write  [MAXC];
    logic [7:0]  in_addr   [MAXC];
    logic [7:0]  in_wdata  [MAXC];
    logic        in_pready [MAXC];
    logic [7:0]  in_prdata [MAXC];
    // Expected outputs per cycle
    logic [31:0] e_cmd_ready [MAXC];
    logic [31:0] e_busy      [MAXC];
    logic [31:0] e_psel      [MAXC];
    logic [31:0] e_penable   [MAXC];
    logic [31:0] e_pwrite    [MAXC];
    logic [31:0] e_paddr     [MAXC];
    logic [31:0] e_pwdata    [MAXC];
    logic [31:0] e_rsp_valid [MAXC];
    logic [31:0] e_rsp_rdata [MAXC];
    logic [31:0] e_rsp_err   [MAXC];
    // Transaction list
    logic        tx_wr    [NTX];
    logic [7:0]  tx_addr  [NTX];
    logic [7:0]  tx_wdata [NTX];
    logic [7:0]  tx_rd    [NTX];
    int          tx_w     [NTX];
    int          tx_gap   [NTX];

    int ncyc;
    int checks;
    int errors;
    int cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cur, act, exp);
        end
    endtask

    task automatic set_tx(input int i, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] rd,
                          input int w, input int gap);
        tx_wr[i]    = wr;
        tx_addr[i]  = a;
        tx_wdata[i] = wd;
        tx_rd[i]    = rd;
        tx_w[i]     = w;
        tx_gap[i]   = gap;
    endtask

    task automatic make_txs();
        set_tx(0, 1'b1, 8'h00, 8'h05, 8'h00, 0, 0);
        set_tx(1, 1'b0, 8'h02, 8'h00, 8'hA5, 3, 0);
        set_tx(2, 1'b1, 8'h00, 8'h01, 8'h00, 0, 0);
        set_tx(3, 1'b1, 8'h01, 8'h82, 8'h00, 0, 0);
        set_tx(4, 1'b0, 8'h03, 8'h00, 8'($urandom), 0, 0);
        set_tx(5, 1'b0, 8'h10, 8'h00, 8'($urandom), TO_EN ? TO : 100, 0);
        set_tx(6, 1'b0, 8'h11, 8'h00, 8'($urandom), TO - 1, 0);
        for (int i = 7; i < NTX; i++) begin
            set_tx(i, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                               : int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)));
        end
    endtask

    // Timeline: handshake H, SETUP H+1, ACCESS from H+2, response the cycle after
    // pready (or after TIMEOUT_CYC dry ACCESS cycles when the watchdog exists).
    task automatic build_model();
        int lastH = 0;
        int free  = 0;
        int s, h, a0, rsp;
        bit ab;
        for (int c = 0; c < MAXC; c++) begin
            in_valid[c]    = 1'b0;
            in_write[c]    = 1'($urandom);
            in_addr[c]     = 8'($urandom);
            in_wdata[c]    = 8'($urandom);
            in_pready[c]   = 1'($urandom);
            in_prdata[c]   = 8'($urandom);
            e_cmd_ready[c] = 1;
            e_busy[c]      = 0;
            e_psel[c]      = 0;
            e_penable[c]   = 0;
            e_pwrite[c]    = 0;
            e_paddr[c]     = 0;
            e_pwdata[c]    = 0;
            e_rsp_valid[c] = 0;
            e_rsp_rdata[c] = 0;
            e_rsp_err[c]   = 0;
        end
        rsp = 0;
        for (int i = 0; i < NTX; i++) begin
            s = lastH + 1 + tx_gap[i];
            h = (s > free) ? s : free;
            for (int c = s; c <= h; c++) begin
                in_valid[c] = 1'b1;
                in_write[c] = tx_wr[i];
                in_addr[c]  = tx_addr[i];
                in_wdata[c] = tx_wdata[i];
            end
            a0 = h + 2;
            ab = TO_EN && (tx_w[i] >= TO);
            if (ab) begin
                for (int c = a0; c < a0 + TO; c++) in_pready[c] = 1'b0;
                rsp = a0 + TO;
            end else begin
                for (int c = a0; c < a0 + tx_w[i]; c++) in_pready[c] = 1'b0;
                in_pready[a0 + tx_w[i]] = 1'b1;
                in_prdata[a0 + tx_w[i]] = tx_rd[i];
                rsp = a0 + tx_w[i] + 1;
            end
            for (int c = h + 1; c < rsp; c++) begin
                e_cmd_ready[c] = 0;
                e_busy[c]      = 1;
                e_psel[c]      = 1;
            end
            for (int c = a0; c < rsp; c++) e_penable[c] = 1;
            for (int c = h + 1; c < MAXC; c++) begin
                e_pwrite[c] = 32'(tx_wr[i]);
                e_paddr[c]  = 32'(tx_addr[i]);
                e_pwdata[c] = 32'(tx_wdata[i]);
            end
            e_rsp_valid[rsp] = 1;
            for (int c = rsp; c < MAXC; c++) begin
                e_rsp_rdata[c] = (tx_wr[i] || ab) ? 32'd0 : 32'(tx_rd[i]);
                e_rsp_err[c]   = ab ? 32'd1 : 32'd0;
            end
            lastH = h;
            free  = rsp;
        end
        ncyc = rsp + 4;
    endtask

    task automatic check_cycle(input int k);
        chk("cmd_ready", 32'(cmd_ready), e_cmd_ready[k]);
        chk("busy",      32'(busy),      e_busy[k]);
        chk("psel",      32'(psel),      e_psel[k]);
        chk("penable",   32'(penable),   e_penable[k]);
        chk("pwrite",    32'(pwrite),    e_pwrite[k]);
        chk("paddr",     32'(paddr),     e_paddr[k]);
        chk("pwdata",    32'(pwdata),    e_pwdata[k]);
        chk("rsp_valid", 32'(rsp_valid), e_rsp_valid[k]);
        chk("rsp_rdata", 32'(rsp_rdata), e_rsp_rdata[k]);
        chk("rsp_err",   32'(rsp_err),   e_rsp_err[k]);
    endtask

    // Hand-computed expectations for the directed transactions.
    task automatic lit_checks(input int k);
        case (k)
            2: begin
                chk("lit_w_setup_psel",    32'(psel),    1);
                chk("lit_w_setup_penable", 32'(penable), 0);
                chk("lit_w_setup_pwrite",  32'(pwrite),  1);
                chk("lit_w_setup_paddr",   32'(paddr),   8'h00);
                chk("lit_w_setup_pwdata",  32'(pwdata),  8'h05);
            end
            3: chk("lit_w_access_penable", 32'(penable), 1);
            4: begin
                chk("lit_w_rsp_valid", 32'(rsp_valid), 1);
                chk("lit_w_rsp_err",   32'(rsp_err),   0);
                chk("lit_w_rsp_rdata", 32'(rsp_rdata), 8'h00);
                chk("lit_w_cmd_ready", 32'(cmd_ready), 1);
            end
            5: chk("lit_r_setup_paddr", 32'(paddr), 8'h02);
            9: begin
                chk("lit_r_wait_penable", 32'(penable), 1);
                chk("lit_r_wait_paddr",   32'(paddr),   8'h02);
            end
            10: begin
                chk("lit_r_rsp_valid", 32'(rsp_valid), 1);
                chk("lit_r_rsp_rdata", 32'(rsp_rdata), 8'hA5);
            end
            11: chk("lit_b2b_cmd_ready", 32'(cmd_ready), 0);
            12: chk("lit_b2b_busy",      32'(busy),      1);
            13: chk("lit_b2b_rsp1",      32'(rsp_valid), 1);
            16: chk("lit_b2b_rsp2",      32'(rsp_valid), 1);
            19: chk("lit_b2b_rsp3",      32'(rsp_valid), 1);
`ifdef TIMER_APB_MASTER_TIMEOUT_EN
            36: chk("lit_to_last_psel", 32'(psel), 1);
            37: begin
                chk("lit_to_rsp_valid", 32'(rsp_valid), 1);
                chk("lit_to_rsp_err",   32'(rsp_err),   1);
                chk("lit_to_rsp_rdata", 32'(rsp_rdata), 8'h00);
                chk("lit_to_psel",      32'(psel),      0);
            end
            55: begin
                chk("lit_edge_rsp_valid", 32'(rsp_valid), 1);
                chk("lit_edge_rsp_err",   32'(rsp_err),   0);
            end
`else
            120: begin
                chk("lit_hang_psel",    32'(psel),    1);
                chk("lit_hang_penable", 32'(penable), 1);
            end
            122: chk("lit_hang_rsp_valid", 32'(rsp_valid), 1);
`endif
            default: ;
        endcase
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cur       = -1;
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        make_txs();
        build_model();

        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_psel",      32'(psel),      0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge pclk);
        #1 presetn = 1'b1;

        for (int k = 0; k < ncyc; k++) begin
            cur       = k;
            cmd_valid = in_valid[k];
            cmd_write = in_write[k];
            cmd_addr  = in_addr[k];
            cmd_wdata = in_wdata[k];
            pready    = in_pready[k];
            prdata    = in_prdata[k];
            @(negedge pclk);
            check_cycle(k);
            lit_checks(k);
            @(posedge pclk);
            #1;
        end

        // Reset pulse in the middle of an ACCESS phase.
        cur       = ncyc;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h44;
        pready    = 1'b0;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(posedge pclk);
        #1;
        chk("rstmid_pre_psel",    32'(psel),    1);
        chk("rstmid_pre_penable", 32'(penable), 1);
        #2 presetn = 1'b0;
        #1;
        chk("rstmid_async_psel",    32'(psel),    0);
        chk("rstmid_async_penable", 32'(penable), 0);
        chk("rstmid_async_busy",    32'(busy),    0);
        pready = 1'b1;
        prdata = 8'h5A;
        @(posedge pclk);
        #1 presetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cur = ncyc + 1 + k;
            @(negedge pclk);
            chk("rstmid_no_rsp", 32'(rsp_valid), 0);
            if (k == 0) begin
                chk("rstmid_cmd_ready", 32'(cmd_ready), 1);
                chk("rstmid_paddr",     32'(paddr),     0);
            end
            @(posedge pclk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
